// File: rtl/d_flip_flop_rst_pkg.sv
// Shared constants for the D-type storage register used across the CPU datapath.
// Wider registers pick their width and reset word from here when no local override is given.
package d_flip_flop_rst_pkg;

    localparam int DFF_DEFAULT_WIDTH = 1;

    // Common reset word for datapath registers that clear to zero.
    localparam logic [63:0] DFF_ZERO_WORD = 64'h0;

    // Width-trimmed reset word helper for registers that want the common zero value.
    function automatic logic [63:0] dff_reset_word(input int width);
        logic [63:0] mask;
        mask = (width >= 64) ? {64{1'b1}} : ((64'h1 << width) - 64'h1);
        return DFF_ZERO_WORD & mask;
    endfunction

endpackage

// File: rtl/d_flip_flop_rst.sv
// D-type register with synchronous active-low reset; q is driven straight from the flops.
// Only the rising clk edge changes q, and reset takes priority over d at that edge.
module d_flip_flop_rst
    import d_flip_flop_rst_pkg::*;
#(
    parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // The select form lets an unknown reset show up as unknown q in 4-state simulation.
    always_ff @(posedge clk) begin
        q <= reset ? d : RESET_VALUE;
    end

endmodule

// File: tb/tb_d_flip_flop_rst.sv
// Bench for d_flip_flop_rst: a default 1-bit instance and an 8-bit instance with reset word A5.
// Directed timing scenarios first, then randomized traffic against a simple reference model.
module tb_d_flip_flop_rst;

    logic       clk;
    logic       reset;
    logic       d;
    logic       q;
    logic       rst8;
    logic [7:0] d8;
    logic [7:0] q8;

    int checks;
    int errors;

    // Scoreboard: expected q values, one entry per clock edge, consumed after the edge.
    logic       exp_q[$];
    logic [7:0] exp8_q[$];

    // Model state: the value q must show between edges.
    logic       model_q;
    logic [7:0] model_q8;

    localparam logic [7:0] RV8 = 8'hA5;

    d_flip_flop_rst dut1 (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .q     (q)
    );

    d_flip_flop_rst #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) dut8 (
        .clk   (clk),
        .reset (rst8),
        .d     (d8),
        .q     (q8)
    );

    // Clock: 10 ns period, starts low, first rising edge at 5 ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL timeout q=%b q8=%h want run to finish", q, q8);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic test_reset;
        reset = 1'b0;
        d     = 1'b0;
        rst8  = 1'b0;
        d8    = 8'h00;
        @(posedge clk); #1;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL reset_q got %b want 0", q);
        end
        checks++;
        if (q8 !== RV8) begin
            errors++;
            $display("FAIL reset_q8 got %h want %h", q8, RV8);
        end
    endtask

    task automatic test_reset_priority;
        @(negedge clk);
        d  = 1'b1;
        d8 = 8'hFF;
        @(posedge clk); #1;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority_q got %b want 0", q);
        end
        checks++;
        if (q8 !== RV8) begin
            errors++;
            $display("FAIL reset_priority_q8 got %h want %h", q8, RV8);
        end
    endtask

    task automatic test_load;
        @(negedge clk);
        reset = 1'b1;
        d     = 1'b0;
        rst8  = 1'b1;
        d8    = 8'h3C;
        @(posedge clk); #1;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL load0_q got %b want 0", q);
        end
        checks++;
        if (q8 !== 8'h3C) begin
            errors++;
            $display("FAIL load_q8 got %h want 3c", q8);
        end
        @(negedge clk);
        d = 1'b1;
        #1 d8 = 8'h11;
        checks++;
        if (q8 !== 8'h3C) begin
            errors++;
            $display("FAIL hold_between_edges_q8 got %h want 3c", q8);
        end
        #2 d8 = 8'h5A;
        @(posedge clk); #1;
        checks++;
        if (q !== 1'b1) begin
            errors++;
            $display("FAIL load1_q got %b want 1", q);
        end
        checks++;
        if (q8 !== 8'h5A) begin
            errors++;
            $display("FAIL load_after_toggle_q8 got %h want 5a", q8);
        end
    endtask

    // Reset asserted between edges must not touch q until the next rising edge.
    task automatic test_sync_reset;
        #1;
        reset = 1'b0;
        rst8  = 1'b0;
        #1;
        checks++;
        if (q !== 1'b1) begin
            errors++;
            $display("FAIL midcycle_reset_q got %b want 1", q);
        end
        checks++;
        if (q8 !== 8'h5A) begin
            errors++;
            $display("FAIL midcycle_reset_q8 got %h want 5a", q8);
        end
        #6;
        checks++;
        if (q !== 1'b1) begin
            errors++;
            $display("FAIL late_midcycle_reset_q got %b want 1", q);
        end
        @(posedge clk); #1;
        checks++;
        if (q !== 1'b0) begin
            errors++;
            $display("FAIL sync_reset_q got %b want 0", q);
        end
        checks++;
        if (q8 !== RV8) begin
            errors++;
            $display("FAIL sync_reset_q8 got %h want %h", q8, RV8);
        end
        model_q  = 1'b0;
        model_q8 = RV8;
    endtask

    // One randomized edge: hold check, drive, predict, check after edge, then glitch inputs.
    task automatic random_edge(input logic r1, input logic r8);
        logic       nd;
        logic [7:0] nd8;
        @(negedge clk);
        checks++;
        if (q !== model_q) begin
            errors++;
            $display("FAIL hold_q got %b want %b", q, model_q);
        end
        checks++;
        if (q8 !== model_q8) begin
            errors++;
            $display("FAIL hold_q8 got %h want %h", q8, model_q8);
        end
        nd    = 1'($urandom_range(0, 1));
        nd8   = 8'($urandom_range(0, 255));
        reset = r1;
        rst8  = r8;
        d     = nd;
        d8    = nd8;
        exp_q.push_back(r1 ? nd : 1'b0);
        exp8_q.push_back(r8 ? nd8 : RV8);
        @(posedge clk); #1;
        model_q  = exp_q.pop_front();
        model_q8 = exp8_q.pop_front();
        checks++;
        if (q !== model_q) begin
            errors++;
            $display("FAIL edge_q got %b want %b", q, model_q);
        end
        checks++;
        if (q8 !== model_q8) begin
            errors++;
            $display("FAIL edge_q8 got %h want %h", q8, model_q8);
        end
        #2;
        d     = 1'($urandom_range(0, 1));
        d8    = 8'($urandom_range(0, 255));
        reset = 1'($urandom_range(0, 1));
        rst8  = 1'($urandom_range(0, 1));
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            random_edge($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
    endtask

    // Long reset hold, then the very first released edge must load d.
    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++) begin
            random_edge(1'b0, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            random_edge(1'b1, 1'b1);
        end
        random_edge(1'b0, 1'b1);
        random_edge(1'b1, 1'b0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        model_q  = 1'b0;
        model_q8 = RV8;
        test_reset();
        test_reset_priority();
        test_load();
        test_sync_reset();
        test_random(300);
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
